// File: rtl/mips_hilo_scheduler_if.sv
// Execute-stage <-> HI/LO scheduler bus. The divZero signal exists only when
// MIPS_HILO_SCHEDULER_DIV_ZERO_EN is defined.
interface mips_hilo_scheduler_if;
    logic        issue;
    logic        mulDiv;
    logic        hilo;
    logic [5:0]  func;
    logic [31:0] rsValue;
    logic [31:0] rtValue;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
    logic        divZero;
`endif

    modport master (
        output issue, mulDiv, hilo, func, rsValue, rtValue, flush,
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
        input  divZero,
`endif
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  issue, mulDiv, hilo, func, rsValue, rtValue, flush,
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
        output divZero,
`endif
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/mips_hilo_scheduler.sv
// HI/LO unit sequencer: fixed-latency multiply, 32-step restoring divide plus sign fix-up.
// Optional early divide-by-zero completion: MIPS_HILO_SCHEDULER_DIV_ZERO_EN.
module mips_hilo_scheduler #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input logic                  clock,
    input logic                  reset,
    mips_hilo_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, SIGN} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] opa, opb;
    logic        op_signed;
    logic [31:0] quot, rem, dmag;
    logic        neg_q, neg_r;
    logic        busy_r, done_r;
    logic [31:0] hi_r, lo_r;
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
    logic        dz, divzero_r;
`endif

    logic        accept, sgn_in;
    logic [31:0] a_mag, b_mag;
    logic [63:0] prod;
    logic [32:0] partial, trial;
    logic [31:0] new_rem, new_quot, q_final, r_final;
    logic        unused_func;

    assign unused_func = ^bus.func[5:2];
    assign accept = bus.issue & ~bus.flush & ~busy_r & (bus.mulDiv | bus.hilo);
    assign sgn_in = ~bus.func[0];
    assign a_mag  = (sgn_in & bus.rsValue[31]) ? -bus.rsValue : bus.rsValue;
    assign b_mag  = (sgn_in & bus.rtValue[31]) ? -bus.rtValue : bus.rtValue;

    always_comb begin
        prod = '0;
        if (op_signed)
            prod = $signed({{32{opa[31]}}, opa}) * $signed({{32{opb[31]}}, opb});
        else
            prod = {32'b0, opa} * {32'b0, opb};
    end

    // One restoring step: shift in the next dividend bit, keep the difference if no borrow.
    always_comb begin
        partial  = {rem, quot[31]};
        trial    = partial - {1'b0, dmag};
        new_rem  = trial[32] ? partial[31:0] : trial[31:0];
        new_quot = {quot[30:0], ~trial[32]};
        q_final  = neg_q ? -quot : quot;
        r_final  = neg_r ? -rem : rem;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            opa       <= '0;
            opb       <= '0;
            op_signed <= 1'b0;
            quot      <= '0;
            rem       <= '0;
            dmag      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hi_r      <= '0;
            lo_r      <= '0;
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
            dz        <= 1'b0;
            divzero_r <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
            divzero_r <= 1'b0;
`endif
            if (bus.flush) begin
                state  <= IDLE;
                busy_r <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && bus.mulDiv) begin
                            opa       <= bus.rsValue;
                            opb       <= bus.rtValue;
                            op_signed <= sgn_in;
                            busy_r    <= 1'b1;
                            if (!bus.func[1]) begin
                                state <= MUL;
                                count <= 5'(MUL_CYCLES - 1);
                            end else begin
                                state <= DIV;
                                count <= '1;
                                quot  <= a_mag;
                                rem   <= '0;
                                dmag  <= b_mag;
                                neg_q <= sgn_in & (bus.rsValue[31] ^ bus.rtValue[31]);
                                neg_r <= sgn_in & bus.rsValue[31];
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
                                dz    <= (bus.rtValue == '0);
`endif
                            end
                        end else if (accept && bus.func[0]) begin
                            if (bus.func[1]) lo_r <= bus.rsValue;
                            else             hi_r <= bus.rsValue;
                        end
                    end
                    MUL: begin
                        if (count == '0) begin
                            {hi_r, lo_r} <= prod;
                            state        <= IDLE;
                            busy_r       <= 1'b0;
                            done_r       <= 1'b1;
                        end else begin
                            count <= count - 5'd1;
                        end
                    end
                    DIV: begin
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
                        if (dz) begin
                            lo_r      <= '1;
                            hi_r      <= opa;
                            state     <= IDLE;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            divzero_r <= 1'b1;
                        end else
`endif
                        begin
                            quot <= new_quot;
                            rem  <= new_rem;
                            if (count == '0) state <= SIGN;
                            else             count <= count - 5'd1;
                        end
                    end
                    SIGN: begin
                        lo_r   <= q_final;
                        hi_r   <= r_final;
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.stall = bus.issue & (bus.mulDiv | bus.hilo) & busy_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
    assign bus.divZero = divzero_r;
`endif
endmodule

// File: tb/tb_mips_hilo_scheduler.sv
// Self-checking bench for mips_hilo_scheduler against an arithmetic reference model.
module tb_mips_hilo_scheduler;
    localparam int MUL_CYCLES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] mhi = '0, mlo = '0;

    always #5 clk = ~clk;

    mips_hilo_scheduler_if bus();

    mips_hilo_scheduler #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate like MIPS DIV.
    function automatic void model(input logic [1:0] f, input logic [31:0] rs, input logic [31:0] rt,
                                  output logic [31:0] ehi, output logic [31:0] elo,
                                  output int lat, output logic edz);
        longint          q, r;
        longint unsigned p;
        edz = 1'b0;
        lat = 33;
        case (f)
            2'd0: begin
                p = longint'($signed(rs)) * longint'($signed(rt));
                {ehi, elo} = p;
                lat = MUL_CYCLES;
            end
            2'd1: begin
                p = longint'({32'b0, rs}) * longint'({32'b0, rt});
                {ehi, elo} = p;
                lat = MUL_CYCLES;
            end
            2'd2: begin
                if (rt == 0) begin
                    elo = rs[31] ? 32'd1 : 32'hFFFF_FFFF;
                    ehi = rs;
                end else begin
                    q = longint'($signed(rs)) / longint'($signed(rt));
                    r = longint'($signed(rs)) % longint'($signed(rt));
                    elo = q[31:0];
                    ehi = r[31:0];
                end
            end
            default: begin
                if (rt == 0) begin
                    elo = 32'hFFFF_FFFF;
                    ehi = rs;
                end else begin
                    q = longint'({32'b0, rs}) / longint'({32'b0, rt});
                    r = longint'({32'b0, rs}) % longint'({32'b0, rt});
                    elo = q[31:0];
                    ehi = r[31:0];
                end
            end
        endcase
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
        if (f[1] && rt == 0) begin
            lat = 1;
            elo = 32'hFFFF_FFFF;
            ehi = rs;
            edz = 1'b1;
        end
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        tests++; if (bus.lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
        rst = 1'b0;
        mhi = '0;
        mlo = '0;
    endtask

    task automatic do_muldiv(input logic [1:0] f, input logic [31:0] rs, input logic [31:0] rt,
                             input string tag);
        logic [31:0] ehi, elo;
        int          lat, n;
        logic        edz;
        model(f, rs, rt, ehi, elo, lat, edz);
        bus.issue = 1'b1; bus.mulDiv = 1'b1; bus.hilo = 1'b0;
        bus.func = {4'b0110, f}; bus.rsValue = rs; bus.rtValue = rt;
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.mulDiv = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        tests++; if (n != lat) begin fails++; $display("FAIL %s_latency got %0d want %0d", tag, n, lat); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL %s_done got %b want 1", tag, bus.done); end
        tests++; if (bus.hi !== ehi) begin fails++; $display("FAIL %s_hi got %h want %h", tag, bus.hi, ehi); end
        tests++; if (bus.lo !== elo) begin fails++; $display("FAIL %s_lo got %h want %h", tag, bus.lo, elo); end
`ifdef MIPS_HILO_SCHEDULER_DIV_ZERO_EN
        tests++; if (bus.divZero !== edz) begin fails++; $display("FAIL %s_divzero got %b want %b", tag, bus.divZero, edz); end
`endif
        @(posedge clk); #1;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL %s_done_pulse got %b want 0", tag, bus.done); end
        mhi = ehi;
        mlo = elo;
    endtask

    task automatic do_mt(input logic to_lo, input logic [31:0] v);
        bus.issue = 1'b1; bus.mulDiv = 1'b0; bus.hilo = 1'b1;
        bus.func = {4'b0100, to_lo, 1'b1}; bus.rsValue = v;
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.hilo = 1'b0;
        if (to_lo) mlo = v; else mhi = v;
        tests++; if (bus.hi !== mhi) begin fails++; $display("FAIL mt_hi got %h want %h", bus.hi, mhi); end
        tests++; if (bus.lo !== mlo) begin fails++; $display("FAIL mt_lo got %h want %h", bus.lo, mlo); end
        tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++; $display("FAIL mt_quiet got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    endtask

    task automatic test_directed();
        do_muldiv(2'd1, 32'hFFFF_FFFF, 32'd2, "multu_max");
        do_muldiv(2'd0, 32'hFFFF_FFFF, 32'd3, "mult_neg");
        do_muldiv(2'd2, -32'sd7, 32'd2, "div_neg");
        do_muldiv(2'd3, 32'd100, 32'd7, "divu_100_7");
        do_muldiv(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        do_muldiv(2'd3, 32'd5, 32'd0, "divu_zero");
        do_muldiv(2'd2, -32'sd9, 32'd0, "div_zero_neg");
    endtask

    task automatic test_mt_mf();
        do_mt(1'b0, 32'h0000_1234);
        do_mt(1'b1, 32'hCAFE_F00D);
        bus.issue = 1'b1; bus.hilo = 1'b1; bus.func = 6'b010000;
        #1;
        tests++; if (bus.stall !== 1'b0) begin fails++; $display("FAIL mfhi_idle_stall got %b want 0", bus.stall); end
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.hilo = 1'b0;
        tests++; if (bus.hi !== mhi || bus.lo !== mlo) begin
            fails++; $display("FAIL mfhi_nochange got %h/%h want %h/%h", bus.hi, bus.lo, mhi, mlo); end
    endtask

    task automatic test_stall();
        logic [31:0] ehi, elo;
        int          lat, n;
        logic        edz;
        model(2'd2, -32'sd7, 32'd2, ehi, elo, lat, edz);
        bus.issue = 1'b1; bus.mulDiv = 1'b1; bus.func = 6'b011010;
        bus.rsValue = -32'sd7; bus.rtValue = 32'd2;
        @(posedge clk); #1;
        bus.mulDiv = 1'b0; bus.hilo = 1'b1; bus.func = 6'b010010;
        #1;
        n = 0;
        while (bus.stall === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #2;
        end
        tests++; if (n != lat) begin fails++; $display("FAIL stall_cycles got %0d want %0d", n, lat); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL stall_drop_done got %b want 1", bus.done); end
        tests++; if (bus.lo !== elo) begin fails++; $display("FAIL stall_mflo got %h want %h", bus.lo, elo); end
        bus.issue = 1'b0; bus.hilo = 1'b0;
        @(posedge clk); #1;
        mhi = ehi;
        mlo = elo;
    endtask

    task automatic test_flush();
        int seen;
        do_mt(1'b0, 32'h0000_1234);
        bus.issue = 1'b1; bus.mulDiv = 1'b1; bus.func = 6'b011011;
        bus.rsValue = $urandom; bus.rtValue = $urandom_range(1, 1000);
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.mulDiv = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL flush_pre_busy got %b want 1", bus.busy); end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", bus.busy); end
        seen = 0;
        repeat (40) begin
            if (bus.done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL flush_no_done got %0d pulses want 0", seen); end
        tests++; if (bus.hi !== mhi || bus.lo !== mlo) begin
            fails++; $display("FAIL flush_hilo got %h/%h want %h/%h", bus.hi, bus.lo, mhi, mlo); end
        // flush in the same cycle as issue: nothing is accepted
        bus.issue = 1'b1; bus.flush = 1'b1; bus.hilo = 1'b1; bus.func = 6'b010011; bus.rsValue = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.hilo = 1'b0; bus.mulDiv = 1'b1; bus.func = 6'b011010;
        tests++; if (bus.lo !== mlo) begin fails++; $display("FAIL flush_wins_mtlo got %h want %h", bus.lo, mlo); end
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.flush = 1'b0; bus.mulDiv = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL flush_wins_div got busy=%b want 0", bus.busy); end
    endtask

    task automatic test_reset_midop();
        int seen;
        bus.issue = 1'b1; bus.mulDiv = 1'b1; bus.func = 6'b011000;
        bus.rsValue = 32'd12345; bus.rtValue = 32'd678;
        @(posedge clk); #1;
        bus.issue = 1'b0; bus.mulDiv = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mhi = '0;
        mlo = '0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        seen = 0;
        repeat (MUL_CYCLES + 3) begin
            if (bus.done === 1'b1) seen++;
            @(posedge clk); #1;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL rst_mid_done got %0d pulses want 0", seen); end
        tests++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            fails++; $display("FAIL rst_mid_hilo got %h/%h want 0/0", bus.hi, bus.lo); end
    endtask

    task automatic test_random();
        logic [31:0] rs, rt;
        logic [1:0]  f;
        for (int i = 0; i < 24; i++) begin
            f = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       rs = 32'h8000_0000;
                1:       rs = 32'hFFFF_FFFF;
                2:       rs = '0;
                default: rs = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rt = '0;
                1:       rt = 32'hFFFF_FFFF;
                2, 3:    rt = $urandom_range(1, 20);
                default: rt = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) do_mt(1'($urandom_range(0, 1)), $urandom);
            do_muldiv(f, rs, rt, "rand");
        end
    endtask

    initial begin
        bus.issue = 1'b0; bus.mulDiv = 1'b0; bus.hilo = 1'b0; bus.func = '0;
        bus.rsValue = '0; bus.rtValue = '0; bus.flush = 1'b0;
        test_reset();
        test_directed();
        test_mt_mf();
        test_stall();
        test_flush();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
